// File: rtl/gate_vec_gen_pkg.sv
// Shared types and constants for the gate stimulus generator.
// The LFSR step lives here so the generator and its sub-module agree on it.
package gate_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } gvg_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic        MODE_EXH  = 1'b0;
  localparam logic        MODE_RND  = 1'b1;

  // Galois LFSR, right shift: feedback applied when the bit shifted out is 1
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/gate_vec_gen_lfsr16.sv
// 16-bit Galois LFSR with synchronous load (priority) and advance enable.
module lfsr16
  import gate_tb_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/gate_vec_gen.sv
// Counted WIDTH-bit vector source over valid/ready, exhaustive or LFSR mode.
// Every output decodes flops only, so vec_ready never reaches vec_valid combinationally.
module gate_vec_gen
  import gate_tb_pkg::*;
#(
  parameter int          WIDTH   = 2,
  parameter int          COUNT_W = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic               vec_ready,
  output logic               vec_valid,
  output logic [WIDTH-1:0]   vec_data,
  output logic [COUNT_W-1:0] vec_idx,
  output logic               busy,
  output logic               done,
  output gvg_state_t         dbg_state
);

  // Handshake: a transfer happens at a rising edge where vec_valid and vec_ready
  // are both high; while vec_valid & !vec_ready, vec_data/vec_idx are held.

  gvg_state_t         state, state_nxt;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] num_q;
  logic               mode_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        cnt_ext;
  logic               launch;
  logic               xfer;
  logic               last_xfer;
  logic               unused_bits;

  assign launch    = (state == IDLE) && start;
  assign xfer      = (state == RUN) && vec_ready;
  assign last_xfer = xfer && ((count_q + 1'b1) == num_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_vec != '0) ? RUN : FIN;
      RUN:     if (last_xfer) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run settings are captured only on launch, so mid-run input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      num_q   <= '0;
      mode_q  <= MODE_EXH;
    end else if (launch) begin
      count_q <= '0;
      num_q   <= num_vec;
      mode_q  <= mode;
    end else if (xfer) begin
      count_q <= count_q + 1'b1;
    end
  end

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .seed (SEED),
    .adv  (xfer),
    .q    (lfsr_q)
  );

  assign cnt_ext     = 16'(count_q);
  assign unused_bits = ^{lfsr_q, cnt_ext};

  assign vec_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign vec_idx   = count_q;
  assign vec_data  = (mode_q == MODE_RND) ? lfsr_q[WIDTH-1:0] : cnt_ext[WIDTH-1:0];
  assign dbg_state = state;

endmodule

// File: tb/tb_gate_vec_gen.sv
// Directed and randomized runs of gate_vec_gen against a queue-based reference.
module tb_gate_vec_gen;
  import gate_tb_pkg::*;

  localparam int WIDTH   = 2;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [COUNT_W-1:0] num_vec = '0;
  logic               vec_ready = 1'b1;
  logic               vec_valid;
  logic [WIDTH-1:0]   vec_data;
  logic [COUNT_W-1:0] vec_idx;
  logic               busy;
  logic               done;
  gvg_state_t         dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_idx_q[$];

  logic             prev_stall = 1'b0;
  logic             prev_done = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [COUNT_W-1:0] prev_idx = '0;

  gate_vec_gen #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .num_vec   (num_vec),
    .vec_ready (vec_ready),
    .vec_valid (vec_valid),
    .vec_data  (vec_data),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read at the falling edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: vectors of a run computed straight from the mode rules
  task automatic push_model(input logic m, input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      if (m) begin
        exp_q.push_back(l[WIDTH-1:0]);
        l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end else begin
        exp_q.push_back(WIDTH'(i % (1 << WIDTH)));
      end
      exp_idx_q.push_back(i);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(vec_valid), 32'd1);
        chk("hold_data", 32'(vec_data), 32'(prev_data));
        chk("hold_idx", 32'(vec_idx), 32'(prev_idx));
      end
      if (vec_valid && vec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL spare_xfer observed=idx %0h expected=no transfer", vec_idx);
        end else begin
          chk("vec_data", 32'(vec_data), 32'(exp_q.pop_front()));
          chk("vec_idx", 32'(vec_idx), 32'(exp_idx_q.pop_front()));
        end
      end
      if (done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        done_cnt++;
      end
      prev_stall = vec_valid & ~vec_ready;
      prev_done  = done;
      prev_data  = vec_data;
      prev_idx   = vec_idx;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic start_run(input logic m, input int n, input bit use_model);
    if (use_model) push_model(m, n);
    tick();
    start   = 1'b1;
    mode    = m;
    num_vec = COUNT_W'(n);
    tick();
    start = 1'b0;
    chk("first_valid", 32'(vec_valid), 32'(n != 0));
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("first_idx", 32'(vec_idx), 32'd0);
  endtask

  task automatic wait_end(input bit bp);
    bit seen;
    int d0;
    seen = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      vec_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("valid_low_at_done", 32'(vec_valid), 32'd0);
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("all_vectors_sent", 32'(exp_q.size()), 32'd0);
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_cleared", 32'(done), 32'd0);
    chk("state_idle", 32'(dbg_state), 32'(IDLE));
    chk("one_done_per_run", 32'(done_cnt - d0), 32'd1);
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  initial begin
    int d0;
    logic m;
    int n;

    // Reset state
    #3;
    chk("rst_valid", 32'(vec_valid), 32'd0);
    chk("rst_data", 32'(vec_data), 32'd0);
    chk("rst_idx", 32'(vec_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    tick();
    rst = 1'b0;

    // 1. Exhaustive wrap
    start_run(MODE_EXH, 6, 1'b1);
    wait_end(1'b0);

    // 2. Random mode, literal sequence then repeat from the model
    exp_q.push_back(2'b01); exp_idx_q.push_back(0);
    exp_q.push_back(2'b00); exp_idx_q.push_back(1);
    exp_q.push_back(2'b00); exp_idx_q.push_back(2);
    start_run(MODE_RND, 3, 1'b0);
    wait_end(1'b0);
    start_run(MODE_RND, 3, 1'b1);
    wait_end(1'b0);

    // 3. Backpressure on vector 2
    start_run(MODE_EXH, 6, 1'b1);
    tick();
    tick();
    vec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_idx_held", 32'(vec_idx), 32'd2);
      chk("bp_data_held", 32'(vec_data), 32'd2);
    end
    vec_ready = 1'b1;
    tick();
    chk("bp_resume_idx", 32'(vec_idx), 32'd3);
    chk("bp_resume_data", 32'(vec_data), 32'd3);
    wait_end(1'b0);

    // 4. Empty run
    start_run(MODE_EXH, 0, 1'b1);
    chk("empty_done_now", 32'(done), 32'd1);
    wait_end(1'b0);

    // 5. Reset mid-run
    start_run(MODE_EXH, 6, 1'b1);
    tick();
    tick();
    chk("pre_rst_idx", 32'(vec_idx), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(vec_valid), 32'd0);
    chk("midrst_data", 32'(vec_data), 32'd0);
    chk("midrst_idx", 32'(vec_idx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    exp_idx_q.delete();
    d0 = done_cnt;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    start_run(MODE_EXH, 4, 1'b1);
    wait_end(1'b0);

    // 6. Start during a run with different settings is ignored
    start_run(MODE_EXH, 5, 1'b1);
    tick();
    start   = 1'b1;
    mode    = MODE_RND;
    num_vec = 8'd2;
    tick();
    start = 1'b0;
    wait_end(1'b0);

    // Randomized runs with random backpressure
    for (int r = 0; r < 10; r++) begin
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 20);
      start_run(m, n, 1'b1);
      wait_end(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
